operand_sel_stage: RTL and testbench
====================================

OPERAND_SEL_STAGE -- requirements
Module: operand_sel_stage

Interface
REQ-001 The block SHALL have parameter WIDTH, default 64, giving the operand data width in bits.
REQ-002 The block SHALL have parameter NSRC, default 4, giving the number of shared source inputs (min 2).
REQ-003 The block SHALL have parameter NCH, default 2, giving the number of independent operand channels (min 1).
REQ-004 The block SHALL have derived parameter SELW = $clog2(NSRC)+1, giving the per-channel select width.
REQ-005 The block SHALL have one clock and an asynchronous active-low reset, ports listed first: clk  in  1  rising-edge clock; rstn  in  1  asynchronous active-low reset.
REQ-006 The block SHALL have port in_valid  in  1  upstream holds valid sources/selects.
REQ-007 The block SHALL have port in_ready  out  1  block can accept this cycle.
REQ-008 The block SHALL have port in_src  in  NSRC*WIDTH  source k at bits [k*WIDTH +: WIDTH].
REQ-009 The block SHALL have port in_sel  in  NCH*SELW  channel c select at bits [c*SELW +: SELW].
REQ-010 The block SHALL have port flush  in  1  synchronous discard of all held entries.
REQ-011 The block SHALL have port out_valid  out  1  out_op holds a valid entry.
REQ-012 The block SHALL have port out_ready  in  1  downstream consumes this cycle.
REQ-013 The block SHALL have port out_op  out  NCH*WIDTH  channel c operand at bits [c*WIDTH +: WIDTH].
REQ-014 The block SHALL have port occ  out  2  number of held entries (0..2).

Function
REQ-015 Per channel c, the selected value SHALL be in_src[sel*WIDTH +: WIDTH] when sel < NSRC, else all-zero (combinational, before capture).
REQ-016 An input transfer SHALL occur on a rising edge with in_valid && in_ready && !flush; an output transfer SHALL occur with out_valid && out_ready && !flush.
REQ-017 Storage SHALL be a main output register plus one skid register, each NCH*WIDTH wide; states EMPTY (occ=0), ONE (occ=1, main full), TWO (occ=2, main and skid full).
REQ-018 in_ready SHALL be a registered signal equal to (state != TWO); it SHALL NOT depend combinationally on out_ready.
REQ-019 out_valid SHALL equal (state != EMPTY); out_op SHALL always drive the main register.
REQ-020 EMPTY + input transfer: capture into main, go ONE; latency from accept to out_valid is 1 cycle.
REQ-021 ONE + input only: capture into skid, go TWO; ONE + output only: go EMPTY; ONE + both: capture into main, stay ONE.
REQ-022 TWO + output transfer: move skid to main, go ONE; no input transfer is possible in TWO.
REQ-023 Entries SHALL leave in acceptance order; no entry SHALL be dropped or duplicated absent flush.
REQ-024 flush SHALL have priority over all transfers: next state EMPTY, occ=0, in_ready=1 next cycle; the entry presented that cycle SHALL NOT be captured.
REQ-025 Data registers SHALL change only on capture; selects and sources are sampled only on the accepting edge.
REQ-026 occ SHALL equal 0/1/2 for EMPTY/ONE/TWO.

Reset
REQ-027 While rstn=0 (asynchronous assertion): state EMPTY, out_valid=0, in_ready=0, occ=0, out_op=0.
REQ-028 in_ready SHALL rise on the first rising clk edge after rstn deasserts.
REQ-029 Reset asserted mid-operation SHALL discard all entries immediately without waiting for a clock.

Verification
REQ-030 NSRC=4, NCH=2, WIDTH=64: src={0x10,0x20,0x30,0x40}, sel={1,2}, in_valid=1, out_ready=1 -> next cycle out_op={ch0 0x20, ch1 0x30}, out_valid=1, occ=1.
REQ-031 sel code 4..7 on ch0, sel 3 on ch1 -> out_op ch0=0, ch1=0x40.
REQ-032 out_ready=0, three back-to-back offers A,B,C -> A,B accepted, occ=2, in_ready=0, C held; out_ready=1 -> A,B,C emerge in order, one per cycle.
REQ-033 State TWO, flush=1 together with out_ready=1 and in_valid=1 -> next cycle occ=0, out_valid=0, in_ready=1, nothing delivered or captured.
REQ-034 rstn pulsed low between clock edges while occ=2 -> out_valid, occ, in_ready drop to 0 immediately; in_ready=1 after first edge following release.
REQ-035 Random in_valid/out_ready 10k cycles against a reference queue -> zero order/data mismatches, occ never exceeds 2.

Source files
------------

// File: rtl/operand_sel_stage.sv
// rtl/operand_sel_stage.sv - per-channel operand select feeding a two-entry skid output stage
module operand_sel_stage #(
   parameter int WIDTH = 64,
   parameter int NSRC  = 4,
   parameter int NCH   = 2,
   localparam int SELW = $clog2(NSRC) + 1
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [NSRC*WIDTH-1:0] in_src,
   input  logic [NCH*SELW-1:0]   in_sel,
   input  logic                  flush,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [NCH*WIDTH-1:0]  out_op,
   output logic [1:0]            occ
);

   typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

   state_t               state, state_nxt;
   logic                 in_ready_q;
   logic [NCH*WIDTH-1:0] main_q, skid_q, sel_bus;
   logic                 in_xfer, out_xfer;
   logic                 ld_main_new, ld_main_skid, ld_skid;
   logic [WIDTH-1:0]     src_arr [NSRC];

   for (genvar k = 0; k < NSRC; k++) begin : g_src
      assign src_arr[k] = in_src[k*WIDTH +: WIDTH];
   end

   // Select codes at or above NSRC yield an all-zero operand.
   for (genvar c = 0; c < NCH; c++) begin : g_ch
      logic [SELW-1:0]  sel_c;
      logic [WIDTH-1:0] chan_val;
      assign sel_c = in_sel[c*SELW +: SELW];
      always_comb begin
         chan_val = '0;
         for (int k = 0; k < NSRC; k++) begin
            if (sel_c == SELW'(k)) chan_val = src_arr[k];
         end
      end
      assign sel_bus[c*WIDTH +: WIDTH] = chan_val;
   end

   assign in_xfer  = in_valid && in_ready_q && !flush;
   assign out_xfer = (state != EMPTY) && out_ready && !flush;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state      <= EMPTY;
         in_ready_q <= 1'b0;
      end else begin
         state      <= state_nxt;
         in_ready_q <= (state_nxt != TWO);
      end
   end

   always_comb begin
      state_nxt = state;
      if (flush) begin
         state_nxt = EMPTY;
      end else begin
         case (state)
            EMPTY:   if (in_xfer) state_nxt = ONE;
            ONE: begin
               if (in_xfer && !out_xfer)      state_nxt = TWO;
               else if (!in_xfer && out_xfer) state_nxt = EMPTY;
            end
            TWO:     if (out_xfer) state_nxt = ONE;
            default: state_nxt = EMPTY;
         endcase
      end
   end

   always_comb begin
      out_valid    = (state != EMPTY);
      occ          = state;
      ld_main_new  = 1'b0;
      ld_main_skid = 1'b0;
      ld_skid      = 1'b0;
      if (!flush) begin
         case (state)
            EMPTY:   ld_main_new = in_xfer;
            ONE: begin
               ld_main_new = in_xfer && out_xfer;
               ld_skid     = in_xfer && !out_xfer;
            end
            TWO:     ld_main_skid = out_xfer;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         main_q <= '0;
         skid_q <= '0;
      end else begin
         if (ld_main_new)       main_q <= sel_bus;
         else if (ld_main_skid) main_q <= skid_q;
         if (ld_skid)           skid_q <= sel_bus;
      end
   end

   assign in_ready = in_ready_q;
   assign out_op   = main_q;

endmodule

// File: tb/tb_operand_sel_stage.sv
// tb/tb_operand_sel_stage.sv - directed and randomized self-checking bench for operand_sel_stage
module tb_operand_sel_stage;

   localparam int WIDTH = 64;
   localparam int NSRC  = 4;
   localparam int NCH   = 2;
   localparam int SELW  = 3;

   logic                  clk = 1'b0;
   logic                  rstn;
   logic                  in_valid;
   logic                  in_ready;
   logic [NSRC*WIDTH-1:0] in_src;
   logic [NCH*SELW-1:0]   in_sel;
   logic                  flush;
   logic                  out_valid;
   logic                  out_ready;
   logic [NCH*WIDTH-1:0]  out_op;
   logic [1:0]            occ;

   int n_tests = 0;
   int n_fail  = 0;

   operand_sel_stage #(.WIDTH(WIDTH), .NSRC(NSRC), .NCH(NCH)) dut (
      .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
      .in_src(in_src), .in_sel(in_sel), .flush(flush), .out_valid(out_valid),
      .out_ready(out_ready), .out_op(out_op), .occ(occ)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_src(input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] c, input logic [63:0] d);
      in_src = {d, c, b, a};
   endtask

   task automatic set_sel(input logic [2:0] s0, input logic [2:0] s1);
      in_sel = {s1, s0};
   endtask

   function automatic logic [127:0] ref_sel(input logic [255:0] src, input logic [5:0] sel);
      logic [127:0] r;
      logic [2:0]   s;
      r = '0;
      for (int c = 0; c < 2; c++) begin
         s = sel[c*3 +: 3];
         if (s < 3'd4) r[c*64 +: 64] = src[s*64 +: 64];
      end
      return r;
   endfunction

   task automatic test_reset();
      rstn = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
      in_src = '0; in_sel = '0;
      #3;
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
      n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got %0b want 0", in_ready); end
      n_tests++; if (occ !== 2'd0) begin n_fail++; $display("FAIL reset_occ got %0d want 0", occ); end
      n_tests++; if (out_op !== '0) begin n_fail++; $display("FAIL reset_out_op got %h want 0", out_op); end
      step();
      n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_held_in_ready got %0b want 0", in_ready); end
      @(negedge clk); rstn = 1'b1; #1;
      n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL release_before_edge got %0b want 0", in_ready); end
      step();
      n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL release_after_edge got %0b want 1", in_ready); end
   endtask

   task automatic test_select();
      set_src(64'h10, 64'h20, 64'h30, 64'h40); set_sel(3'd1, 3'd2);
      in_valid = 1'b1; out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      n_tests++; if (out_op !== {64'h30, 64'h20}) begin n_fail++; $display("FAIL select_op got %h want 30/20", out_op); end
      n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL select_valid got %0b want 1", out_valid); end
      n_tests++; if (occ !== 2'd1) begin n_fail++; $display("FAIL select_occ got %0d want 1", occ); end
      step();
      n_tests++; if (occ !== 2'd0) begin n_fail++; $display("FAIL select_drain_occ got %0d want 0", occ); end
   endtask

   task automatic test_out_of_range();
      set_src(64'h10, 64'h20, 64'h30, 64'h40);
      in_valid = 1'b1; out_ready = 1'b1;
      for (int s = 4; s < 8; s++) begin
         set_sel(3'(s), 3'd3);
         step();
         n_tests++; if (out_op !== {64'h40, 64'h0}) begin n_fail++; $display("FAIL oor_sel%0d got %h want 40/0", s, out_op); end
      end
      in_valid = 1'b0;
      step();
   endtask

   task automatic test_back_to_back();
      logic [127:0] ea, eb, ec;
      ea = {64'h2, 64'h1}; eb = {64'h14, 64'h13}; ec = {64'h21, 64'h24};
      out_ready = 1'b0; in_valid = 1'b1;
      set_src(64'h1, 64'h2, 64'h3, 64'h4); set_sel(3'd0, 3'd1);
      step();
      set_src(64'h11, 64'h12, 64'h13, 64'h14); set_sel(3'd2, 3'd3);
      step();
      n_tests++; if (occ !== 2'd2) begin n_fail++; $display("FAIL b2b_full_occ got %0d want 2", occ); end
      n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_full_ready got %0b want 0", in_ready); end
      set_src(64'h21, 64'h22, 64'h23, 64'h24); set_sel(3'd3, 3'd0);
      step();
      n_tests++; if (occ !== 2'd2) begin n_fail++; $display("FAIL b2b_held_occ got %0d want 2", occ); end
      n_tests++; if (out_op !== ea) begin n_fail++; $display("FAIL b2b_first got %h want %h", out_op, ea); end
      out_ready = 1'b1;
      step();
      n_tests++; if (out_op !== eb) begin n_fail++; $display("FAIL b2b_second got %h want %h", out_op, eb); end
      n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_back got %0b want 1", in_ready); end
      step();
      in_valid = 1'b0;
      n_tests++; if (out_op !== ec) begin n_fail++; $display("FAIL b2b_third got %h want %h", out_op, ec); end
      n_tests++; if (occ !== 2'd1) begin n_fail++; $display("FAIL b2b_third_occ got %0d want 1", occ); end
      step();
      n_tests++; if (occ !== 2'd0) begin n_fail++; $display("FAIL b2b_drain_occ got %0d want 0", occ); end
   endtask

   task automatic test_flush();
      out_ready = 1'b0; in_valid = 1'b1;
      set_src(64'h5, 64'h6, 64'h7, 64'h8); set_sel(3'd0, 3'd0);
      step(); step();
      n_tests++; if (occ !== 2'd2) begin n_fail++; $display("FAIL flush_fill_occ got %0d want 2", occ); end
      flush = 1'b1; out_ready = 1'b1;
      step();
      flush = 1'b0; in_valid = 1'b0;
      n_tests++; if (occ !== 2'd0) begin n_fail++; $display("FAIL flush_occ got %0d want 0", occ); end
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid got %0b want 0", out_valid); end
      n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_ready got %0b want 1", in_ready); end
      step();
      n_tests++; if (occ !== 2'd0) begin n_fail++; $display("FAIL flush_no_capture got %0d want 0", occ); end
   endtask

   task automatic test_async_reset();
      out_ready = 1'b0; in_valid = 1'b1;
      set_src(64'h9, 64'hA, 64'hB, 64'hC); set_sel(3'd1, 3'd2);
      step(); step();
      in_valid = 1'b0;
      n_tests++; if (occ !== 2'd2) begin n_fail++; $display("FAIL arst_fill_occ got %0d want 2", occ); end
      #2 rstn = 1'b0;
      #1;
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_valid got %0b want 0", out_valid); end
      n_tests++; if (occ !== 2'd0) begin n_fail++; $display("FAIL arst_occ got %0d want 0", occ); end
      n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL arst_ready got %0b want 0", in_ready); end
      #1 rstn = 1'b1;
      step();
      n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL arst_release_ready got %0b want 1", in_ready); end
   endtask

   task automatic test_random();
      logic [127:0] q[$];
      logic [127:0] exp_val;
      logic         in_fire, out_fire;
      for (int i = 0; i < 10000; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         in_src    = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         in_sel    = 6'($urandom_range(0, 63));
         n_tests++; if (in_ready !== (q.size() < 2)) begin n_fail++; $display("FAIL rand_ready cyc %0d got %0b want %0b", i, in_ready, q.size() < 2); end
         n_tests++; if (occ !== 2'(q.size())) begin n_fail++; $display("FAIL rand_occ cyc %0d got %0d want %0d", i, occ, q.size()); end
         in_fire  = in_valid && (q.size() < 2);
         out_fire = out_ready && (q.size() > 0);
         if (out_fire) begin
            exp_val = q.pop_front();
            n_tests++; if (out_op !== exp_val) begin n_fail++; $display("FAIL rand_data cyc %0d got %h want %h", i, out_op, exp_val); end
         end
         if (in_fire) q.push_back(ref_sel(in_src, in_sel));
         step();
      end
      in_valid = 1'b0; out_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_select();
      test_out_of_range();
      test_back_to_back();
      test_flush();
      test_async_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
